// File: rtl/dbg_reg_readout_if.sv
// Serial debug-readback port: capture request/word in, valid/ready bit stream out.
interface dbg_reg_readout_if #(
  parameter int unsigned N = 32
);
  logic         req;
  logic [N-1:0] data_in;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         busy;
  logic         done;

  modport master (
    output req, data_in, ser_ready,
    input  ser_out, ser_valid, busy, done
  );

  modport slave (
    input  req, data_in, ser_ready,
    output ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/dbg_reg_readout.sv
// Captures an N-bit register value and shifts it out MSB first over valid/ready.
// Optional DBG_READOUT_PARITY_EN appends an even-parity beat after bit 0.
module dbg_reg_readout #(
  parameter int unsigned N = 32
) (
  input logic               clk,
  input logic               reset_n,
  dbg_reg_readout_if.slave  bus
);
  localparam int unsigned CntW = $clog2(N);

`ifdef DBG_READOUT_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic {StIdle, StShift} state_e;
`endif

  state_e          state_q, state_d;
  logic [N-1:0]    shift_q;
  logic [CntW-1:0] cnt_q;
  logic            done_q;
  logic            capture;
  logic            last_beat;
  logic            advance;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic; in SHIFT/PAR ser_valid is always 1, so ser_ready alone marks a handshake
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    last_beat = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          state_d = StShift;
          capture = 1'b1;
        end
      end
      StShift: begin
        if (bus.ser_ready && (cnt_q == '0)) begin
`ifdef DBG_READOUT_PARITY_EN
          state_d   = StPar;
`else
          state_d   = StIdle;
          last_beat = 1'b1;
`endif
        end
      end
`ifdef DBG_READOUT_PARITY_EN
      StPar: begin
        if (bus.ser_ready) begin
          state_d   = StIdle;
          last_beat = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign advance = (state_q == StShift) && bus.ser_ready;

  // Shift register and beat counter; counter saturates at 0 rather than wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (capture) begin
      shift_q <= bus.data_in;
      cnt_q   <= CntW'(N - 1);
    end else if (advance) begin
      shift_q <= {shift_q[N-2:0], 1'b0};
      if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done_q <= 1'b0;
    else          done_q <= last_beat;
  end

`ifdef DBG_READOUT_PARITY_EN
  // Parity comes from a capture-time copy since the shift register is drained by then
  logic parity_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     parity_q <= 1'b0;
    else if (capture) parity_q <= ^bus.data_in;
  end
`endif

  // Outputs decode only flop state; no path from req or ser_ready
  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.ser_valid = (state_q != StIdle);
    bus.done      = done_q;
`ifdef DBG_READOUT_PARITY_EN
    bus.ser_out   = (state_q == StPar) ? parity_q : shift_q[N-1];
`else
    bus.ser_out   = shift_q[N-1];
`endif
  end

endmodule

// File: tb/tb_dbg_reg_readout.sv
// Directed bench for dbg_reg_readout: vector table of transfers plus hand-written corner sequences.
module tb_dbg_reg_readout;
  localparam int unsigned N = 32;
`ifdef DBG_READOUT_PARITY_EN
  localparam int ExtraBeats = 1;
`else
  localparam int ExtraBeats = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  dbg_reg_readout_if #(.N(N)) bus ();

  dbg_reg_readout #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] d;
    int          stall_beat;
    int          stall_len;
    int          poke_beat;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, ":busy"},  32'(bus.busy),      32'd0);
    check({name, ":valid"}, 32'(bus.ser_valid), 32'd0);
    check({name, ":done"},  32'(bus.done),      32'd0);
  endtask

  // One transfer. Cycle c counts edges after the capture edge; done is expected at c == exp_lat.
  task automatic xfer(input logic [31:0] d, input int stall_beat, input int stall_len,
                      input int poke_beat, input int exp_lat, input bit capture,
                      input bit hold, input string name);
    int   k;
    int   stalled;
    bit   poked;
    logic eb;
    k       = 0;
    stalled = 0;
    poked   = 1'b0;
    if (capture) begin
      bus.req       = 1'b1;
      bus.data_in   = d;
      bus.ser_ready = 1'b1;
      tick();
    end
    for (int c = 1; c <= exp_lat; c++) begin
      eb = (k < int'(N)) ? d[N-1-k] : ^d;
      check({name, ":busy"},  32'(bus.busy),      32'd1);
      check({name, ":valid"}, 32'(bus.ser_valid), 32'd1);
      check({name, ":bit"},   32'(bus.ser_out),   32'(eb));
      check({name, ":done"},  32'(bus.done),      32'd0);
      if (k == stall_beat && stalled < stall_len) begin
        bus.ser_ready = 1'b0;
        stalled++;
      end else begin
        bus.ser_ready = 1'b1;
      end
      if (k == poke_beat && !poked) begin
        bus.req     = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
        poked       = 1'b1;
      end else begin
        bus.req     = hold;
        bus.data_in = hold ? d : ~d;
      end
      tick();
      if (bus.ser_ready) k++;
    end
    check({name, ":done_pulse"}, 32'(bus.done),      32'd1);
    check({name, ":busy_end"},   32'(bus.busy),      32'd0);
    check({name, ":valid_end"},  32'(bus.ser_valid), 32'd0);
    bus.ser_ready = 1'b1;
    if (hold) begin
      tick();
      bus.req = 1'b0;
    end else begin
      bus.req = 1'b0;
      tick();
      check_idle({name, ":after1"});
      tick();
      check_idle({name, ":after2"});
    end
  endtask

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, -1, 0, -1, 32 + ExtraBeats, "basic_a5a5"};
    vecs[1] = '{32'h8000_0001,  5, 3, -1, 35 + ExtraBeats, "stall_b5"};
    vecs[2] = '{32'h0000_0000, -1, 0, 10, 32 + ExtraBeats, "req_busy"};
    vecs[3] = '{32'hFFFF_FFFE,  0, 2, -1, 34 + ExtraBeats, "stall_first"};
    vecs[4] = '{32'h0000_0001, 31, 1, -1, 33 + ExtraBeats, "stall_last"};
    vecs[5] = '{32'h0000_0007, -1, 0, -1, 32 + ExtraBeats, "par_7"};
    vecs[6] = '{32'h0000_0003, -1, 0, -1, 32 + ExtraBeats, "par_3"};

    reset_n       = 1'b0;
    bus.req       = 1'b0;
    bus.data_in   = '0;
    bus.ser_ready = 1'b0;
    #12;
    check_idle("reset");
    check("reset:ser_out", 32'(bus.ser_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check_idle("post_reset");

    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].d, vecs[i].stall_beat, vecs[i].stall_len, vecs[i].poke_beat,
           vecs[i].exp_lat, 1'b1, 1'b0, vecs[i].name);
    end

    // Back-to-back: req held high, second capture on the done cycle, no valid gap
    xfer(32'h1234_5678, -1, 0, -1, 32 + ExtraBeats, 1'b1, 1'b1, "b2b_first");
    xfer(32'h1234_5678, -1, 0, -1, 32 + ExtraBeats, 1'b0, 1'b0, "b2b_second");

    // Reset mid-shift at beat 17: outputs clear without a clock edge, no done afterwards
    bus.req       = 1'b1;
    bus.data_in   = 32'hFFFF_FFFF;
    bus.ser_ready = 1'b1;
    tick();
    bus.req = 1'b0;
    repeat (17) tick();
    check("midrst:pre_bit",   32'(bus.ser_out),   32'd1);
    check("midrst:pre_valid", 32'(bus.ser_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("midrst:async");
    check("midrst:async_bit", 32'(bus.ser_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_idle("midrst:idle");
      check("midrst:idle_bit", 32'(bus.ser_out), 32'd0);
    end
    xfer(32'hC3C3_3C3C, -1, 0, -1, 32 + ExtraBeats, 1'b1, 1'b0, "midrst:recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dbg_reg_readout.md
# dbg_reg_readout

Debug readback serializer for the single-cycle MIPS datapath. It captures an n-bit value from a datapath register's Q output on request. It then shifts the value out one bit per accepted handshake, MSB first, through a valid/ready serial port. It is the read-side counterpart of the enable-gated state registers, so register contents (PC, ALU result, register-file word) can be observed off-chip without stalling the datapath.

## Interface
- N, 32, width of captured word; legal range 2..64
- clk  input  1  rising-edge clock
- reset_n  input  1  reset reset_n, asynchronous, active-low; clock clk
- req  input  1  start request; sampled only in IDLE
- data_in  input  N  register value to capture
- ser_out  output  1  current serial bit
- ser_valid  output  1  ser_out holds a valid bit
- ser_ready  input  1  downstream accepts bit when ser_valid && ser_ready at posedge
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the final bit is accepted

## Operation
- State machine:
  - IDLE: busy=0, ser_valid=0.
  - SHIFT: busy=1, ser_valid=1.
  - PAR: only with the macro; busy=1, ser_valid=1.
- IDLE→SHIFT: req=1 at a posedge. The same edge loads the shift register with data_in and loads bit_cnt with N-1.
- In SHIFT, ser_out = shift register MSB.
- On each accepted handshake (ser_valid && ser_ready), the register shifts left by 1 with 0 filled in, and bit_cnt decrements.
- A handshake with bit_cnt==0 exits SHIFT:
  - without the macro, to IDLE;
  - with the macro, to PAR.
- No handshake: state, shift register, counter and ser_out hold indefinitely.
- req while busy=1 is ignored. It is neither queued nor used to restart.
- data_in is sampled only at the capture edge; later changes have no effect.
- done is registered. It is 1 for exactly the one cycle following the final accepted handshake, which is also the first IDLE cycle.
- A req present in that done cycle is accepted, so back-to-back transfers are allowed.
- bit_cnt width: $clog2(N). No wrap: the counter is reloaded on capture and never decremented below 0.
- Reset (async, any state including mid-transfer) aborts the transfer:
  - state=IDLE, shift register=0, bit_cnt=0;
  - ser_out=0, ser_valid=0, busy=0, done=0;
  - no done pulse is produced for the aborted transfer.

## Timing
- Reset values: ser_out=0, ser_valid=0, busy=0, done=0.
- Capture edge E0 (req=1 in IDLE). In the cycle after E0: busy=1, ser_valid=1, ser_out=data_in[N-1].
- With ser_ready held at 1:
  - bit k (N-1 down to 0) is accepted at edge E0+(N-k);
  - done=1 and busy=0 in the cycle after E0+N, i.e. N cycles after the capture.
- Each cycle with ser_ready=0 while ser_valid=1 adds exactly one cycle of latency.
- All outputs come directly from flops; there is no combinational path from ser_ready or req to any output.

## Configuration
- DBG_READOUT_PARITY_EN: when defined, one extra PAR beat follows bit 0.
  - ser_out = even parity (XOR reduction) of the captured word; ser_valid=1.
  - done is pulsed after that beat is accepted. Total beats N+1; done N+1 cycles after capture with ser_ready=1.
  - Parity is computed from a copy latched at the capture edge.
- When undefined: no PAR state and no parity logic; exactly N beats.

## Test plan
- Reset, then req=1 with data_in=0xA5A50F0F and ser_ready=1:
  - ser_out sequence is 1,0,1,0,0,1,0,1,…,1,1,1,1 (MSB first);
  - done pulses exactly once, 32 cycles after the capture edge;
  - busy falls in that same cycle.
- Backpressure: data_in=0x80000001, ser_ready=0 for 3 cycles while bit 5 is presented:
  - ser_out and ser_valid stay stable for those cycles;
  - done is delayed to 35 cycles after capture;
  - the bit sequence is unchanged.
- req while busy: pulse req with data_in=0xFFFFFFFF at beat 10 of a 0x00000000 transfer:
  - it is ignored; all 32 bits are 0;
  - exactly one done pulse occurs.
- Back-to-back: hold req=1 continuously with data_in=0x12345678:
  - second capture occurs on the done cycle;
  - the next ser_valid follows with no gap cycle.
- Reset mid-shift: assert reset_n=0 at beat 17:
  - all outputs are 0 immediately (async);
  - after release the block is in IDLE, with no done pulse until a new req.
- With DBG_READOUT_PARITY_EN defined, data_in=0x00000007:
  - 33 beats; beat 33 has ser_out=1;
  - done 33 cycles after capture.
  - Repeat with 0x00000003: parity beat is 0.
